// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the lifo_stack family: default sizes, a constant
// log2 helper for deriving widths, and the per-cycle operation decode.
package lifo_stack_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   // Smallest r such that 2**r >= value; usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Encoding matches {Push, Pop} so the request pair casts directly.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_SWAP = 2'b11
   } stack_op_t;

endpackage

// File: rtl/lifo_stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port,
// so it maps onto distributed RAM.
module lifo_stack_ram
   import lifo_stack_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = clog2(DEF_DEPTH)
) (
   input  logic              Clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: contents are never cleared, only overwritten.
   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO with same-cycle push+pop (replace top / bypass when
// empty), combinational peek, occupancy flags and sticky error flags.
module lifo_stack
   import lifo_stack_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AFULL_LVL = DEPTH - 1,
   parameter int CNT_W     = clog2(DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              Push,
   input  logic              Pop,
   input  logic              ClrErr,
   output logic [DATA_W-1:0] DataOut,
   output logic              DataValid,
   output logic [DATA_W-1:0] Top,
   output logic [CNT_W-1:0]  Count,
   output logic              Full,
   output logic              Empty,
   output logic              AlmostFull,
   output logic              Overflow,
   output logic              Underflow
);

   localparam int ADDR_W = clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LVL);

   logic [CNT_W-1:0]  count_reg;
   logic [DATA_W-1:0] data_out_reg;
   logic              valid_reg;
   logic              ovf_reg;
   logic              unf_reg;

   stack_op_t         op;
   logic              full;
   logic              empty;
   logic [ADDR_W-1:0] top_addr;
   logic [ADDR_W-1:0] push_addr;
   logic [DATA_W-1:0] top_data;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;

   assign op        = stack_op_t'({Push, Pop});
   assign full      = (count_reg == CNT_DEPTH);
   assign empty     = (count_reg == '0);
   // When empty top_addr wraps, but its data is masked off below.
   assign top_addr  = ADDR_W'(count_reg - CNT_ONE);
   assign push_addr = ADDR_W'(count_reg);

   lifo_stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .Clk   (Clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (DataIn),
      .raddr (top_addr),
      .rdata (top_data)
   );

   // Write decode: push appends, push+pop replaces the current top in place.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = push_addr;
      case (op)
         OP_PUSH: ram_we = !full;
         OP_SWAP: begin
            ram_we    = !empty;
            ram_waddr = top_addr;
         end
         default: ;
      endcase
      if (Reset) ram_we = 1'b0;
   end

   // Occupancy, output register, strobe and sticky flags.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_reg    <= '0;
         data_out_reg <= '0;
         valid_reg    <= 1'b0;
         ovf_reg      <= 1'b0;
         unf_reg      <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         // A new error later in this block overrides the clear.
         if (ClrErr) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
         end
         case (op)
            OP_PUSH: begin
               if (full) ovf_reg   <= 1'b1;
               else      count_reg <= count_reg + CNT_ONE;
            end
            OP_POP: begin
               if (empty) begin
                  unf_reg <= 1'b1;
               end else begin
                  data_out_reg <= top_data;
                  valid_reg    <= 1'b1;
                  count_reg    <= count_reg - CNT_ONE;
               end
            end
            OP_SWAP: begin
               data_out_reg <= empty ? DataIn : top_data;
               valid_reg    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign DataOut    = data_out_reg;
   assign DataValid  = valid_reg;
   assign Top        = empty ? '0 : top_data;
   assign Count      = count_reg;
   assign Full       = full;
   assign Empty      = empty;
   assign AlmostFull = (count_reg >= CNT_AFULL);
   assign Overflow   = ovf_reg;
   assign Underflow  = unf_reg;

endmodule
